// File: rtl/strm_reduce_engine.sv
// Stream map-reduce engine: per-lane key match or value, per-beat reduce, per-frame accumulate.
// Optional build macro STRM_REDUCE_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module strm_reduce_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int KEY_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [KEY_WIDTH-1:0]               i_key,
  input  logic [KEY_WIDTH-1:0]               i_key_mask,
  input  logic                               i_mode,
  input  logic [DATA_WIDTH-1:0]              i_strm_data,
  input  logic [DATA_WIDTH/KEY_WIDTH-1:0]    i_strm_keep,
  input  logic                               i_strm_last,
  input  logic                               i_strm_data_valid,
  output logic                               o_strm_data_rdy,
  output logic [CNT_WIDTH-1:0]               o_result_data,
  output logic [CNT_WIDTH-1:0]               o_beat_count,
  output logic                               o_overflow,
  output logic                               o_result_valid,
  input  logic                               i_result_ack
);

  localparam int LANES     = DATA_WIDTH / KEY_WIDTH;
  localparam int RED_WIDTH = KEY_WIDTH + $clog2(LANES);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic                              rdy_q, first_q;
  logic [KEY_WIDTH-1:0]              key_q, mask_q;
  logic                              mode_q;
  logic [LANES-1:0][KEY_WIDTH-1:0]   map_q, map_d;
  logic                              map_v_q;
  logic [RED_WIDTH-1:0]              red_q, red_d;
  logic                              red_v_q;
  logic [CNT_WIDTH-1:0]              acc_q, acc_next, cnt_q;
  logic [CNT_WIDTH:0]                acc_sum;
  logic                              ovf_q;
  logic [CNT_WIDTH-1:0]              res_data_q, res_cnt_q;
  logic                              res_ovf_q, res_valid_q;

  logic                 accept, ack_hs, load_res;
  logic [KEY_WIDTH-1:0] cfg_key, cfg_mask;
  logic                 cfg_mode;

  assign accept = i_strm_data_valid && rdy_q;
  assign ack_hs = i_result_ack && res_valid_q;

  // The first beat of a frame uses the live configuration; later beats use the latched copy.
  assign cfg_key  = first_q ? i_key      : key_q;
  assign cfg_mask = first_q ? i_key_mask : mask_q;
  assign cfg_mode = first_q ? i_mode     : mode_q;

  always_comb begin
    map_d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_strm_keep[k]) begin
        if (cfg_mode) begin
          map_d[k] = i_strm_data[k*KEY_WIDTH +: KEY_WIDTH];
        end else if (((i_strm_data[k*KEY_WIDTH +: KEY_WIDTH] ^ cfg_key) & cfg_mask) == '0) begin
          map_d[k] = KEY_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    red_d = '0;
    for (int k = 0; k < LANES; k++) begin
      red_d = red_d + RED_WIDTH'(map_q[k]);
    end
  end

  assign acc_sum = {1'b0, acc_q} + (CNT_WIDTH+1)'(red_q);

`ifdef STRM_REDUCE_SATURATE_EN
  assign acc_next = (ovf_q || acc_sum[CNT_WIDTH]) ? '1 : acc_sum[CNT_WIDTH-1:0];
`else
  assign acc_next = acc_sum[CNT_WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (accept && i_strm_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!map_v_q && !red_v_q) state_d = ST_HOLD;
      ST_HOLD:  if (ack_hs) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign load_res = (state_q == ST_DRAIN) && (state_d == ST_HOLD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      rdy_q       <= 1'b0;
      first_q     <= 1'b1;
      key_q       <= '0;
      mask_q      <= '0;
      mode_q      <= 1'b0;
      map_q       <= '0;
      map_v_q     <= 1'b0;
      red_q       <= '0;
      red_v_q     <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_RUN);
      map_v_q <= accept;
      red_v_q <= map_v_q;
      if (accept) begin
        map_q   <= map_d;
        cnt_q   <= cnt_q + CNT_WIDTH'(1);
        first_q <= 1'b0;
        if (first_q) begin
          key_q  <= i_key;
          mask_q <= i_key_mask;
          mode_q <= i_mode;
        end
      end
      if (map_v_q) red_q <= red_d;
      if (red_v_q) begin
        acc_q <= acc_next;
        if (acc_sum[CNT_WIDTH]) ovf_q <= 1'b1;
      end
      if (load_res) begin
        res_data_q  <= acc_q;
        res_cnt_q   <= cnt_q;
        res_ovf_q   <= ovf_q;
        res_valid_q <= 1'b1;
      end
      if (ack_hs) begin
        res_valid_q <= 1'b0;
        acc_q       <= '0;
        cnt_q       <= '0;
        ovf_q       <= 1'b0;
        first_q     <= 1'b1;
      end
    end
  end

  assign o_strm_data_rdy = rdy_q;
  assign o_result_data   = res_data_q;
  assign o_beat_count    = res_cnt_q;
  assign o_overflow      = res_ovf_q;
  assign o_result_valid  = res_valid_q;

endmodule

// File: tb/tb_strm_reduce_engine.sv
// Scoreboard bench: drives a default engine and a CNT_WIDTH=12 engine with the same stream.
module tb_strm_reduce_engine;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  key, mask;
  logic        mode;
  logic [63:0] data;
  logic [7:0]  keep;
  logic        last, valid, ack;

  logic        rdy_a, ovf_a, val_a;
  logic [31:0] res_a, cnt_a;
  logic        rdy_b, ovf_b, val_b;
  logic [11:0] res_b, cnt_b;

  strm_reduce_engine dut_a (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_key_mask(mask), .i_mode(mode),
    .i_strm_data(data), .i_strm_keep(keep), .i_strm_last(last), .i_strm_data_valid(valid),
    .o_strm_data_rdy(rdy_a), .o_result_data(res_a), .o_beat_count(cnt_a),
    .o_overflow(ovf_a), .o_result_valid(val_a), .i_result_ack(ack)
  );

  strm_reduce_engine #(.CNT_WIDTH(12)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_key_mask(mask), .i_mode(mode),
    .i_strm_data(data), .i_strm_keep(keep), .i_strm_last(last), .i_strm_data_valid(valid),
    .o_strm_data_rdy(rdy_b), .o_result_data(res_b), .o_beat_count(cnt_b),
    .o_overflow(ovf_b), .o_result_valid(val_b), .i_result_ack(ack)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] cnt;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   seen_a = 1'b0;
  bit   seen_b = 1'b0;

  localparam logic [63:0] DMIX = 64'h4141_0000_4141_4141;
  localparam logic [63:0] DFF  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] D01  = 64'h0101_0101_0101_0101;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (val_a && !seen_a) begin
      seen_a = 1'b1;
      if (q_a.size() == 0) begin
        total++;
        $display("FAIL a_unexpected_result: got 0x%0h expected none", res_a);
      end else begin
        e = q_a.pop_front();
        chk("a_result", res_a, e.res);
        chk("a_beats", cnt_a, e.cnt);
        chk("a_overflow", {31'b0, ovf_a}, {31'b0, e.ovf});
        chk("a_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (!val_a) begin
      seen_a = 1'b0;
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (val_b && !seen_b) begin
      seen_b = 1'b1;
      if (q_b.size() == 0) begin
        total++;
        $display("FAIL b_unexpected_result: got 0x%0h expected none", res_b);
      end else begin
        e = q_b.pop_front();
        chk("b_result", {20'b0, res_b}, e.res);
        chk("b_beats", {20'b0, cnt_b}, e.cnt);
        chk("b_overflow", {31'b0, ovf_b}, {31'b0, e.ovf});
        chk("b_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (!val_b) begin
      seen_b = 1'b0;
    end
  end

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n = 0;
    data  = d;
    keep  = k;
    last  = l;
    valid = 1'b1;
    while (!rdy_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy_a) begin
      total++;
      $display("FAIL rdy_timeout: got rdy 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    if (l) last_cyc = cyc;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic expect_frame(input logic [31:0] ra, input logic [31:0] rb, input logic [31:0] c,
                              input logic oa, input logic ob);
    exp_t e;
    e.cnt = c;
    e.cyc = last_cyc + 3;
    e.res = ra;
    e.ovf = oa;
    q_a.push_back(e);
    e.res = rb;
    e.ovf = ob;
    q_b.push_back(e);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!val_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!val_a) begin
      total++;
      $display("FAIL valid_timeout: got valid 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic ack_result();
    wait_valid();
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("rdy_after_ack", {31'b0, rdy_a}, 32'd1);
    chk("valid_after_ack", {31'b0, val_a}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; key = 8'h41; mask = 8'hFF; mode = 1'b0;
    data = '0; keep = '0; last = 1'b0; valid = 1'b0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy", {31'b0, rdy_a}, 32'd0);
    chk("reset_valid", {31'b0, val_a}, 32'd0);
    chk("reset_result", res_a, 32'd0);
    chk("reset_beats", cnt_a, 32'd0);
    chk("reset_overflow", {31'b0, ovf_a}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_reset", {31'b0, rdy_a}, 32'd1);

    // Stray ack with no result pending must be ignored.
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("stray_ack_rdy", {31'b0, rdy_a}, 32'd1);

    // Key match; config changes after the first beat must not take effect.
    key = 8'h41; mask = 8'hFF; mode = 1'b0;
    beat(DMIX, 8'hFF, 1'b0);
    key = 8'h00; mode = 1'b1;
    beat(DMIX, 8'hFF, 1'b1);
    chk("rdy_falls_on_last", {31'b0, rdy_a}, 32'd0);
    expect_frame(32'd12, 32'd12, 32'd2, 1'b0, 1'b0);
    ack_result();

    key = 8'h41; mask = 8'hFF; mode = 1'b0;
    beat(DMIX, 8'h0F, 1'b0);
    beat(DMIX, 8'h0F, 1'b1);
    expect_frame(32'd8, 32'd8, 32'd2, 1'b0, 1'b0);
    ack_result();

    mask = 8'h00;
    beat(DMIX, 8'hFF, 1'b0);
    beat(DMIX, 8'hFF, 1'b1);
    expect_frame(32'd16, 32'd16, 32'd2, 1'b0, 1'b0);
    ack_result();

    mode = 1'b1;
    beat(DFF, 8'hFF, 1'b1);
    expect_frame(32'd2040, 32'd2040, 32'd1, 1'b0, 1'b0);
    ack_result();

    // Last beat with nothing kept.
    mode = 1'b0; mask = 8'hFF;
    beat(DMIX, 8'h00, 1'b1);
    expect_frame(32'd0, 32'd0, 32'd1, 1'b0, 1'b0);
    ack_result();

    // Back-pressure while the result is held.
    beat(DMIX, 8'hFF, 1'b1);
    expect_frame(32'd6, 32'd6, 32'd1, 1'b0, 1'b0);
    wait_valid();
    data = DFF; keep = 8'hFF; valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_rdy", {31'b0, rdy_a}, 32'd0);
      chk("hold_result", res_a, 32'd6);
      chk("hold_beats", cnt_a, 32'd1);
    end
    valid = 1'b0;
    ack_result();
    mode = 1'b1;
    beat(D01, 8'hFF, 1'b1);
    expect_frame(32'd8, 32'd8, 32'd1, 1'b0, 1'b0);
    ack_result();

    // Overflow on the 12-bit engine: 3 * 2040 = 6120.
    mode = 1'b1;
    beat(DFF, 8'hFF, 1'b0);
    beat(DFF, 8'hFF, 1'b0);
    beat(DFF, 8'hFF, 1'b1);
`ifdef STRM_REDUCE_SATURATE_EN
    expect_frame(32'd6120, 32'h0000_0FFF, 32'd3, 1'b0, 1'b1);
`else
    expect_frame(32'd6120, 32'h0000_07E8, 32'd3, 1'b0, 1'b1);
`endif
    ack_result();

    // Reset in mid-frame discards the partial frame.
    beat(DFF, 8'hFF, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midreset_valid", {31'b0, val_a}, 32'd0);
    mode = 1'b1;
    beat(D01, 8'hFF, 1'b1);
    expect_frame(32'd8, 32'd8, 32'd1, 1'b0, 1'b0);
    ack_result();

    repeat (10) @(posedge clk);
    #1;
    chk("queue_a_drained", 32'(q_a.size()), 32'd0);
    chk("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/strm_reduce_engine.md
# strm_reduce_engine

Parametrised stream map-reduce engine; successor to the fixed 64-bit stream counters on the PCIe/DDR stream ports of the user logic. Each stream beat is split into LANES = DATA_WIDTH/KEY_WIDTH lanes. Each lane is mapped to either a masked key-match bit or its own value. The lane results are reduced per beat and accumulated per frame. On the frame-end beat, the frame total and the beat count are delivered on a valid/ack result port. The engine back-pressures the input stream while a result is pending.

## Interface
- DATA_WIDTH, 64, input stream width; must be a multiple of KEY_WIDTH
- KEY_WIDTH, 8, lane width in bits
- CNT_WIDTH, 32, result and beat-count width; must be ≥ KEY_WIDTH+clog2(LANES)
- i_clk  in  1  single clock; all logic is on this clock
- i_rst  in  1  synchronous, active-high reset
- i_key  in  KEY_WIDTH  match key (mode 0)
- i_key_mask  in  KEY_WIDTH  compare mask; a 1 bit means the bit is compared
- i_mode  in  1  0 = count matching lanes, 1 = sum lane values
- i_strm_data  in  DATA_WIDTH  stream data; lane k is bits [k*KEY_WIDTH +: KEY_WIDTH]
- i_strm_keep  in  LANES  per-lane enable; unkept lanes contribute 0
- i_strm_last  in  1  final beat of the frame
- i_strm_data_valid  in  1  beat valid
- o_strm_data_rdy  out  1  engine accepts a beat
- o_result_data  out  CNT_WIDTH  frame total
- o_beat_count  out  CNT_WIDTH  accepted beats in the frame, wrapping
- o_overflow  out  1  the frame total exceeded 2^CNT_WIDTH−1
- o_result_valid  out  1  result valid
- i_result_ack  in  1  result consumed

## Operation
- Beat accept: i_strm_data_valid && o_strm_data_rdy at a rising edge.
- i_key, i_key_mask and i_mode are latched on the first accepted beat of each frame and held until that frame's result is acked.
- Map stage, per lane:
  - Mode 0: the lane maps to 1 if (lane & mask) == (key & mask) and its keep bit is set, else 0. Mask 0 matches every kept lane.
  - Mode 1: the lane maps to its value if kept, else 0.
- Reduce stage: sum of all lanes, width KEY_WIDTH+clog2(LANES).
- Accumulate stage: the accumulator sums at CNT_WIDTH+1 bits. o_overflow is sticky per frame and sets when a sum's bit CNT_WIDTH is 1; the stored accumulator is then handled per Configuration.
- State machine:
  - RUN → DRAIN on accepting a last beat.
  - DRAIN → HOLD once the pipeline is empty; the result registers load on entering HOLD.
  - HOLD → RUN on the i_result_ack handshake, which also clears the accumulator, beat counter and overflow flag.
- o_strm_data_rdy is 1 only in RUN.
- A last beat with i_strm_keep = 0 gives result 0 and a beat count of at least 1.
- Within RUN, throughput is 1 beat per cycle; there are no bubbles between consecutive beats.

## Timing
- Reset values: o_strm_data_rdy=0, o_result_valid=0, o_result_data=0, o_beat_count=0, o_overflow=0. State = RUN; rdy rises on the first edge after i_rst deasserts.
- Last beat accepted at edge T:
  - Map register loads at T, reduce register at T+1, accumulator at T+2.
  - o_result_valid and the result outputs change at edge T+3 (latency 3).
- o_strm_data_rdy falls at edge T; the beat presented at T+1 is not accepted.
- Result handshake at edge R: o_result_valid falls at R and o_strm_data_rdy rises at R. The earliest next-frame beat is accepted at R+1.
- The result outputs are stable while o_result_valid=1 and i_result_ack=0.
- i_result_ack while o_result_valid=0 is ignored.
- i_rst mid-frame or in HOLD discards all partial state; no result is emitted for the interrupted frame.

## Configuration
- STRM_REDUCE_SATURATE_EN defined: on overflow the accumulator clamps to 2^CNT_WIDTH−1 and stays there for the rest of the frame.
- STRM_REDUCE_SATURATE_EN undefined: the accumulator wraps mod 2^CNT_WIDTH.
- o_overflow behaves identically in both builds.

## Test plan
- Defaults, mode 0, key 0x41, mask 0xFF, keep 0xFF; 2 beats of 0x4141_0000_4141_4141, last on beat 2 -> result 12, beat count 2, overflow 0, valid 3 cycles after the last beat.
- Same data, keep 0x0F on both beats -> result 8; mask 0x00, keep 0xFF -> result 16.
- Mode 1, 1 beat of all 0xFF, keep 0xFF -> result 2040, beat count 1.
- Back-pressure: hold i_result_ack low 10 cycles, valid driven continuously -> rdy stays 0, outputs unchanged, no beat accepted; ack -> rdy 1 the next cycle; next frame result is independent of the previous one.
- CNT_WIDTH=12, mode 1, 3 beats of all 0xFF -> overflow 1; result 0xFFF with STRM_REDUCE_SATURATE_EN, 0x7E8 without.
- Assert i_rst after 1 beat of a 3-beat frame, then send a fresh 1-beat mode-1 frame of 0x01 in each lane -> exactly one result, value 8, beat count 1.
